// File: rtl/mac_frame_sequencer.sv
// mac_frame_sequencer
//   Frame-level controller for one MAC dot-product of N taps. It loads N
//   coefficients, then N signal samples, clears the accumulator, streams both
//   FIFOs into the datapath in lock-step, waits out the datapath latency and
//   then loads the result. The coefficient FIFO is rewound at the end of every
//   frame so a later frame with the same N can skip the coefficient load.
//
// Ports
//   clk_i, rst_i                    clock, synchronous active-high reset
//   start_i, keep_coeff_i           frame request (IDLE only), reuse coeffs
//   num_taps_i                      taps N, latched on an accepted start
//   coeff_valid_i / coeff_ready_o   host coefficient handshake
//   sig_valid_i / sig_ready_o       host signal handshake
//   coeff_full_i, sig_full_i        FIFO full flags
//   coeff_empty_i, sig_empty_i      FIFO empty flags
//   wr_en_coeff_o, wr_en_signal_o   FIFO write enables
//   rd_en_coeff_o, rd_en_signal_o   paired FIFO read enables
//   redo_coeff_o                    rewind coefficient FIFO read pointer
//   acc_clr_o, ld_result_o          accumulator clear, result load
//   busy_o, done_o, err_o           status (err_o sticky until reset)
module mac_frame_sequencer #(
  parameter int ADDR_LINES = 4,
  parameter int PIPE_LAT   = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  keep_coeff_i,
  input  logic [ADDR_LINES:0]   num_taps_i,
  input  logic                  coeff_valid_i,
  output logic                  coeff_ready_o,
  input  logic                  sig_valid_i,
  output logic                  sig_ready_o,
  input  logic                  coeff_full_i,
  input  logic                  sig_full_i,
  input  logic                  coeff_empty_i,
  input  logic                  sig_empty_i,
  output logic                  wr_en_coeff_o,
  output logic                  wr_en_signal_o,
  output logic                  rd_en_coeff_o,
  output logic                  rd_en_signal_o,
  output logic                  redo_coeff_o,
  output logic                  acc_clr_o,
  output logic                  ld_result_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int CW = ADDR_LINES + 1;
  localparam int LW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CW-1:0] NMAX     = {1'b1, {ADDR_LINES{1'b0}}};
  localparam logic [LW-1:0] LAT_LAST = LW'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, LD_COEFF, LD_SIG, CLR, COMPUTE, DRAIN, DONE
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] n_reg;
  logic [CW-1:0] stored_n_reg;
  logic          coeff_ok_reg;
  logic [LW-1:0] lat_reg;
  logic          acc_clr_reg;
  logic          ld_result_reg;
  logic          done_reg;
  logic          redo_reg;
  logic          busy_reg;
  logic          err_reg;

  logic [CW-1:0] cnt_inc;
  logic          n_ok;
  logic          keep_ok;
  logic          rd_pair;

  // cnt is one bit wider than the address so N = NMAX is reachable.
  assign cnt_inc = cnt_reg + CW'(1);
  assign n_ok    = (num_taps_i != '0) && (num_taps_i <= NMAX);
  assign keep_ok = !keep_coeff_i || (coeff_ok_reg && (stored_n_reg == num_taps_i));

  // Ready depends only on state, count and full so the host may wait on it.
  assign coeff_ready_o  = (state_reg == LD_COEFF) && (cnt_reg < n_reg) && !coeff_full_i;
  assign sig_ready_o    = (state_reg == LD_SIG) && (cnt_reg < n_reg) && !sig_full_i;
  assign wr_en_coeff_o  = coeff_valid_i && coeff_ready_o;
  assign wr_en_signal_o = sig_valid_i && sig_ready_o;

  // Both FIFOs advance together or not at all, keeping the tap pairs aligned.
  assign rd_pair        = (state_reg == COMPUTE) && !coeff_empty_i && !sig_empty_i;
  assign rd_en_coeff_o  = rd_pair;
  assign rd_en_signal_o = rd_pair;

  assign acc_clr_o    = acc_clr_reg;
  assign ld_result_o  = ld_result_reg;
  assign done_o       = done_reg;
  assign redo_coeff_o = redo_reg;
  assign busy_o       = busy_reg;
  assign err_o        = err_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      n_reg         <= '0;
      stored_n_reg  <= '0;
      coeff_ok_reg  <= 1'b0;
      lat_reg       <= '0;
      acc_clr_reg   <= 1'b0;
      ld_result_reg <= 1'b0;
      done_reg      <= 1'b0;
      redo_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      acc_clr_reg   <= 1'b0;
      ld_result_reg <= 1'b0;
      done_reg      <= 1'b0;
      redo_reg      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            if (n_ok && keep_ok) begin
              n_reg    <= num_taps_i;
              cnt_reg  <= '0;
              busy_reg <= 1'b1;
              if (keep_coeff_i) begin
                state_reg <= LD_SIG;
              end else begin
                // Overwriting the FIFO makes the stored set unusable until
                // this load completes a whole frame.
                state_reg    <= LD_COEFF;
                coeff_ok_reg <= 1'b0;
              end
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        LD_COEFF: begin
          if (wr_en_coeff_o) begin
            if (cnt_inc == n_reg) begin
              cnt_reg   <= '0;
              state_reg <= LD_SIG;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
        end
        LD_SIG: begin
          if (wr_en_signal_o) begin
            if (cnt_inc == n_reg) begin
              cnt_reg     <= '0;
              state_reg   <= CLR;
              acc_clr_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
        end
        CLR: begin
          state_reg <= COMPUTE;
        end
        COMPUTE: begin
          if (rd_pair) begin
            if (cnt_inc == n_reg) begin
              cnt_reg   <= '0;
              lat_reg   <= '0;
              state_reg <= DRAIN;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
        end
        DRAIN: begin
          if (lat_reg == LAT_LAST) begin
            state_reg     <= DONE;
            ld_result_reg <= 1'b1;
            done_reg      <= 1'b1;
            redo_reg      <= 1'b1;
          end else begin
            lat_reg <= lat_reg + LW'(1);
          end
        end
        DONE: begin
          state_reg    <= IDLE;
          busy_reg     <= 1'b0;
          coeff_ok_reg <= 1'b1;
          stored_n_reg <= n_reg;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_frame_sequencer.sv
// Testbench for mac_frame_sequencer: randomized host/FIFO-flag stimulus,
// checked against a frame-level model (tap counts, ordering rules, latency
// arithmetic and coefficient-reuse bookkeeping).
module tb_mac_frame_sequencer;

  localparam int AL   = 4;
  localparam int PL   = 3;
  localparam int NMAX = 16;

  logic        clk = 1'b0;
  logic        rst_i, start_i, keep_coeff_i;
  logic [AL:0] num_taps_i;
  logic        coeff_valid_i, sig_valid_i;
  logic        coeff_full_i, sig_full_i, coeff_empty_i, sig_empty_i;
  logic        coeff_ready_o, sig_ready_o, wr_en_coeff_o, wr_en_signal_o;
  logic        rd_en_coeff_o, rd_en_signal_o, redo_coeff_o, acc_clr_o;
  logic        ld_result_o, busy_o, done_o, err_o;

  always #5 clk = ~clk;

  mac_frame_sequencer #(.ADDR_LINES(AL), .PIPE_LAT(PL)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .keep_coeff_i(keep_coeff_i),
    .num_taps_i(num_taps_i), .coeff_valid_i(coeff_valid_i), .coeff_ready_o(coeff_ready_o),
    .sig_valid_i(sig_valid_i), .sig_ready_o(sig_ready_o), .coeff_full_i(coeff_full_i),
    .sig_full_i(sig_full_i), .coeff_empty_i(coeff_empty_i), .sig_empty_i(sig_empty_i),
    .wr_en_coeff_o(wr_en_coeff_o), .wr_en_signal_o(wr_en_signal_o),
    .rd_en_coeff_o(rd_en_coeff_o), .rd_en_signal_o(rd_en_signal_o),
    .redo_coeff_o(redo_coeff_o), .acc_clr_o(acc_clr_o), .ld_result_o(ld_result_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;

  // Frame-level reference state
  bit m_coeff_ok = 1'b0;
  int m_n        = 0;
  bit m_err      = 1'b0;

  // Observations collected by the drivers
  int o_wc, o_ws, o_rd, o_clr, o_done, o_lat, o_viol, o_full_blocked, o_busy;
  bit o_timeout;

  function automatic int frame_latency(input int n, input bit keep, input int extra);
    return (keep ? 0 : n) + n + 1 + n + PL + 1 + extra;
  endfunction

  task automatic idle_inputs();
    start_i = 1'b0; keep_coeff_i = 1'b0; num_taps_i = '0;
    coeff_valid_i = 1'b0; sig_valid_i = 1'b0;
    coeff_full_i = 1'b0; sig_full_i = 1'b0; coeff_empty_i = 1'b0; sig_empty_i = 1'b0;
  endtask

  // Called and returns just after a rising edge; drives one whole frame.
  task automatic run_frame(input int n, input bit keep, input int vpct, input int fpct,
                           input int epct, input int stall_at, input int stall_len,
                           input int full_at, input int full_len);
    int k, s_left, f_left;
    bit done_seen, forced_full;
    o_wc = 0; o_ws = 0; o_rd = 0; o_clr = 0; o_done = 0; o_lat = 0;
    o_viol = 0; o_full_blocked = 0; o_timeout = 1'b0;
    idle_inputs();
    start_i = 1'b1; keep_coeff_i = keep; num_taps_i = 5'(n);
    if (!keep) m_coeff_ok = 1'b0;
    @(negedge clk);
    if (busy_o !== 1'b0 || done_o !== 1'b0 || coeff_ready_o !== 1'b0 || sig_ready_o !== 1'b0)
      o_viol++;
    @(posedge clk); #1;
    start_i = 1'b0; keep_coeff_i = 1'b0;
    k = 1; s_left = stall_len; f_left = full_len; done_seen = 1'b0;
    while (!done_seen && k < 2000) begin
      coeff_valid_i = int'($urandom_range(99)) < vpct;
      sig_valid_i   = int'($urandom_range(99)) < vpct;
      coeff_full_i  = int'($urandom_range(99)) < fpct;
      sig_full_i    = int'($urandom_range(99)) < fpct;
      coeff_empty_i = int'($urandom_range(99)) < epct;
      sig_empty_i   = int'($urandom_range(99)) < epct;
      forced_full = 1'b0;
      if (full_len > 0 && o_wc == full_at && f_left > 0) begin
        coeff_full_i = 1'b1; coeff_valid_i = 1'b1; forced_full = 1'b1; f_left--;
      end
      if (stall_len > 0 && o_rd == stall_at && s_left > 0) begin
        sig_empty_i = 1'b1; s_left--;
      end
      @(negedge clk);
      if (forced_full && coeff_ready_o === 1'b0) o_full_blocked++;
      if (wr_en_coeff_o === 1'b1 && !(coeff_valid_i && coeff_ready_o)) o_viol++;
      if (wr_en_signal_o === 1'b1 && !(sig_valid_i && sig_ready_o)) o_viol++;
      if (coeff_ready_o === 1'b1 && (coeff_full_i || keep || o_wc >= n)) o_viol++;
      if (sig_ready_o === 1'b1 && (sig_full_i || o_ws >= n || (!keep && o_wc < n))) o_viol++;
      if (rd_en_coeff_o !== rd_en_signal_o) o_viol++;
      if (rd_en_coeff_o === 1'b1 && (coeff_empty_i || sig_empty_i || o_clr == 0 || o_ws < n)) o_viol++;
      if (acc_clr_o === 1'b1 && o_ws < n) o_viol++;
      if (done_o !== ld_result_o || done_o !== redo_coeff_o) o_viol++;
      if (done_o === 1'b1 && o_rd < n) o_viol++;
      if (busy_o !== 1'b1) o_viol++;
      if (wr_en_coeff_o === 1'b1) o_wc++;
      if (wr_en_signal_o === 1'b1) o_ws++;
      if (rd_en_coeff_o === 1'b1) o_rd++;
      if (acc_clr_o === 1'b1) o_clr++;
      if (done_o === 1'b1) begin o_done++; done_seen = 1'b1; o_lat = k; end
      @(posedge clk); #1;
      k++;
    end
    idle_inputs();
    if (!done_seen) o_timeout = 1'b1;
    else begin m_coeff_ok = 1'b1; m_n = n; end
  endtask

  // Issues one start that the model predicts will be refused, then watches.
  task automatic try_reject(input int n, input bit keep);
    o_busy = 0; o_wc = 0;
    idle_inputs();
    start_i = 1'b1; keep_coeff_i = keep; num_taps_i = 5'(n);
    coeff_valid_i = 1'b1; sig_valid_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy_o !== 1'b0) o_busy++;
      if (wr_en_coeff_o !== 1'b0 || wr_en_signal_o !== 1'b0) o_wc++;
      @(posedge clk); #1;
    end
    idle_inputs();
    m_err = 1'b1;
  endtask

  task automatic test_reset();
    logic [11:0] outs;
    idle_inputs();
    rst_i = 1'b1; start_i = 1'b1; coeff_valid_i = 1'b1; sig_valid_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    outs = {coeff_ready_o, sig_ready_o, wr_en_coeff_o, wr_en_signal_o, rd_en_coeff_o,
            rd_en_signal_o, redo_coeff_o, acc_clr_o, ld_result_o, busy_o, done_o, err_o};
    checks++;
    if (outs !== 12'h000) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", outs, 12'h000);
    end
    rst_i = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_frame(4, 1'b0, 100, 0, 0, 0, 0, 0, 0);
    $display("basic frame: N=4 wc=%0d ws=%0d rd=%0d lat=%0d", o_wc, o_ws, o_rd, o_lat);
    checks++; if (o_timeout) begin errors++; $display("FAIL basic_timeout: got 1 expected 0"); end
    checks++; if (o_wc != 4) begin errors++; $display("FAIL basic_coeff_writes: got %0d expected 4", o_wc); end
    checks++; if (o_ws != 4) begin errors++; $display("FAIL basic_sig_writes: got %0d expected 4", o_ws); end
    checks++; if (o_rd != 4) begin errors++; $display("FAIL basic_reads: got %0d expected 4", o_rd); end
    checks++; if (o_clr != 1) begin errors++; $display("FAIL basic_acc_clr: got %0d expected 1", o_clr); end
    checks++; if (o_lat != frame_latency(4, 1'b0, 0))
      begin errors++; $display("FAIL basic_latency: got %0d expected %0d", o_lat, frame_latency(4, 1'b0, 0)); end
    checks++; if (o_viol != 0) begin errors++; $display("FAIL basic_rules: got %0d violations expected 0", o_viol); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", err_o); end
  endtask

  // Starts in the IDLE cycle directly after the previous DONE.
  task automatic test_back_to_back_keep();
    run_frame(4, 1'b1, 100, 0, 0, 0, 0, 0, 0);
    $display("keep frame: N=4 wc=%0d ws=%0d rd=%0d lat=%0d", o_wc, o_ws, o_rd, o_lat);
    checks++; if (o_wc != 0) begin errors++; $display("FAIL keep_coeff_writes: got %0d expected 0", o_wc); end
    checks++; if (o_ws != 4) begin errors++; $display("FAIL keep_sig_writes: got %0d expected 4", o_ws); end
    checks++; if (o_rd != 4) begin errors++; $display("FAIL keep_reads: got %0d expected 4", o_rd); end
    checks++; if (o_lat != frame_latency(4, 1'b1, 0))
      begin errors++; $display("FAIL keep_latency: got %0d expected %0d", o_lat, frame_latency(4, 1'b1, 0)); end
    checks++; if (o_viol != 0) begin errors++; $display("FAIL keep_rules: got %0d violations expected 0", o_viol); end
  endtask

  task automatic test_keep_mismatch();
    try_reject(3, 1'b1);
    $display("keep reject: N=3 busy_cycles=%0d err=%b", o_busy, err_o);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL keep_mismatch_err: got %b expected 1", err_o); end
    checks++; if (o_busy != 0) begin errors++; $display("FAIL keep_mismatch_busy: got %0d expected 0", o_busy); end
    checks++; if (o_wc != 0) begin errors++; $display("FAIL keep_mismatch_writes: got %0d expected 0", o_wc); end
  endtask

  task automatic test_sig_stall();
    run_frame(4, 1'b0, 100, 0, 0, 2, 2, 0, 0);
    $display("stall frame: N=4 rd=%0d lat=%0d", o_rd, o_lat);
    checks++; if (o_rd != 4) begin errors++; $display("FAIL stall_reads: got %0d expected 4", o_rd); end
    checks++; if (o_lat != frame_latency(4, 1'b0, 2))
      begin errors++; $display("FAIL stall_latency: got %0d expected %0d", o_lat, frame_latency(4, 1'b0, 2)); end
    checks++; if (o_viol != 0) begin errors++; $display("FAIL stall_rules: got %0d violations expected 0", o_viol); end
  endtask

  task automatic test_full_hold();
    run_frame(4, 1'b0, 100, 0, 0, 0, 0, 2, 3);
    $display("full-hold frame: N=4 wc=%0d blocked=%0d lat=%0d", o_wc, o_full_blocked, o_lat);
    checks++; if (o_wc != 4) begin errors++; $display("FAIL full_coeff_writes: got %0d expected 4", o_wc); end
    checks++; if (o_full_blocked != 3) begin errors++; $display("FAIL full_ready_low: got %0d expected 3", o_full_blocked); end
    checks++; if (o_lat != frame_latency(4, 1'b0, 3))
      begin errors++; $display("FAIL full_latency: got %0d expected %0d", o_lat, frame_latency(4, 1'b0, 3)); end
    checks++; if (o_viol != 0) begin errors++; $display("FAIL full_rules: got %0d violations expected 0", o_viol); end
  endtask

  task automatic test_nmax();
    run_frame(NMAX, 1'b0, 100, 0, 0, 0, 0, 0, 0);
    $display("nmax frame: N=%0d wc=%0d ws=%0d rd=%0d lat=%0d", NMAX, o_wc, o_ws, o_rd, o_lat);
    checks++; if (o_wc != NMAX || o_ws != NMAX || o_rd != NMAX)
      begin errors++; $display("FAIL nmax_counts: got %0d/%0d/%0d expected %0d each", o_wc, o_ws, o_rd, NMAX); end
    checks++; if (o_lat != frame_latency(NMAX, 1'b0, 0))
      begin errors++; $display("FAIL nmax_latency: got %0d expected %0d", o_lat, frame_latency(NMAX, 1'b0, 0)); end
    checks++; if (o_viol != 0) begin errors++; $display("FAIL nmax_rules: got %0d violations expected 0", o_viol); end
  endtask

  task automatic test_bad_n();
    int bad [2] = '{0, NMAX + 1};
    foreach (bad[i]) begin
      try_reject(bad[i], 1'b0);
      $display("bad N=%0d: busy_cycles=%0d err=%b", bad[i], o_busy, err_o);
      checks++; if (o_busy != 0 || o_wc != 0)
        begin errors++; $display("FAIL bad_n_busy: N=%0d got busy=%0d writes=%0d expected 0", bad[i], o_busy, o_wc); end
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL bad_n_err: N=%0d got %b expected 1", bad[i], err_o); end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 14; f++) begin
      int n; bit keep; bit accept; int vp, fp, ep;
      n = ($urandom_range(2) == 0 && m_n != 0) ? m_n : int'($urandom_range(NMAX, 1));
      keep = $urandom_range(1);
      accept = !keep || (m_coeff_ok && m_n == n);
      if (accept) begin
        vp = $urandom_range(100, 50); fp = $urandom_range(30); ep = $urandom_range(30);
        run_frame(n, keep, vp, fp, ep, 0, 0, 0, 0);
        $display("random frame %0d: N=%0d keep=%0d wc=%0d ws=%0d rd=%0d clr=%0d done=%0d", f, n, keep, o_wc, o_ws, o_rd, o_clr, o_done);
        checks++; if (o_timeout) begin errors++; $display("FAIL rand_timeout: frame %0d got 1 expected 0", f); end
        checks++; if (o_wc != (keep ? 0 : n)) begin errors++; $display("FAIL rand_coeff_writes: got %0d expected %0d", o_wc, keep ? 0 : n); end
        checks++; if (o_ws != n || o_rd != n) begin errors++; $display("FAIL rand_sig_reads: got %0d/%0d expected %0d", o_ws, o_rd, n); end
        checks++; if (o_clr != 1 || o_done != 1) begin errors++; $display("FAIL rand_pulses: got clr=%0d done=%0d expected 1/1", o_clr, o_done); end
        checks++; if (o_viol != 0) begin errors++; $display("FAIL rand_rules: got %0d violations expected 0", o_viol); end
      end else begin
        try_reject(n, keep);
        $display("random reject %0d: N=%0d keep=%0d busy_cycles=%0d", f, n, keep, o_busy);
        checks++; if (o_busy != 0) begin errors++; $display("FAIL rand_reject_busy: got %0d expected 0", o_busy); end
      end
      checks++; if (err_o !== m_err) begin errors++; $display("FAIL rand_err: got %b expected %b", err_o, m_err); end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] outs;
    bit seen = 1'b0;
    idle_inputs();
    start_i = 1'b1; num_taps_i = 5'(4);
    @(posedge clk); #1;
    start_i = 1'b0; coeff_valid_i = 1'b1; sig_valid_i = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (rd_en_coeff_o === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL midrst_reach_compute: got 0 expected 1"); end
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    m_coeff_ok = 1'b0; m_err = 1'b0;
    @(negedge clk);
    outs = {coeff_ready_o, sig_ready_o, wr_en_coeff_o, wr_en_signal_o, rd_en_coeff_o,
            rd_en_signal_o, redo_coeff_o, acc_clr_o, ld_result_o, busy_o, done_o, err_o};
    $display("mid-frame reset: outputs=%b", outs);
    checks++; if (outs !== 12'h000) begin errors++; $display("FAIL midrst_outputs: got %b expected %b", outs, 12'h000); end
    @(posedge clk); #1;
    try_reject(4, 1'b1);
    $display("post-reset keep start: busy_cycles=%0d err=%b", o_busy, err_o);
    checks++; if (o_busy != 0) begin errors++; $display("FAIL midrst_keep_busy: got %0d expected 0", o_busy); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL midrst_keep_err: got %b expected 1", err_o); end
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back_keep();
    test_keep_mismatch();
    test_sig_stall();
    test_full_hold();
    test_nmax();
    test_bad_n();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
